// File: rtl/maze_generator.sv
// Binary-tree maze writer for the ROWS x COLS wall bitmap (1 = wall, col = bit index).
// Optional build macro MAZE_EXIT_EN opens an exit in the right border beside the bottom-right cell.
module maze_generator #(
  parameter int          ROWS      = 20,
  parameter int          COLS      = 20,
  parameter logic [15:0] SEED_ZERO = 16'hACE1
) (
  input  logic            Clk,
  input  logic            Reset_n,
  input  logic            start,
  input  logic [15:0]     seed,
  output logic            busy,
  output logic            done,
  output logic            maze_valid,
  output logic [COLS-1:0] maze [0:ROWS-1]
);

  // state  | meaning
  // IDLE   | waiting for start; maze holds the last result
  // FILL   | one row per cycle set to all walls
  // CARVE  | one odd/odd cell opened per cycle, plus north or east passage
  // FINISH | done pulse, maze marked valid
  typedef enum logic [1:0] {IDLE, FILL, CARVE, FINISH} state_t;

  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(COLS);
  localparam logic [RW-1:0] ROW_LAST  = RW'(ROWS - 1);
  localparam logic [RW-1:0] ROW_CARVE = RW'(ROWS - 3);
  localparam logic [CW-1:0] COL_CARVE = CW'(COLS - 3);

  state_t        state, state_nx;
  logic [RW-1:0] row;
  logic [CW-1:0] col;
  logic [15:0]   lfsr;
  logic [15:0]   lfsr_nx;
  logic          go_east, go_north, last_cell;

  assign lfsr_nx   = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  assign last_cell = (row == ROW_CARVE) && (col == COL_CARVE);

  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      IDLE:   if (start) state_nx = FILL;
      FILL: begin
        busy = 1'b1;
        if (row == ROW_LAST) state_nx = CARVE;
      end
      CARVE: begin
        busy = 1'b1;
        if (last_cell) state_nx = FINISH;
      end
      FINISH: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Top carve row can only go east; rightmost carve column can only go north.
  always_comb begin
    go_east  = 1'b0;
    go_north = 1'b0;
    if (row == RW'(1))           go_east  = (col != COL_CARVE);
    else if (col == COL_CARVE)   go_north = 1'b1;
    else if (lfsr[0])            go_east  = 1'b1;
    else                         go_north = 1'b1;
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state      <= IDLE;
      maze_valid <= 1'b0;
      lfsr       <= SEED_ZERO;
      row        <= '0;
      col        <= '0;
      for (int r = 0; r < ROWS; r++) maze[r] <= '1;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: if (start) begin
          lfsr       <= (seed == 16'h0) ? SEED_ZERO : seed;
          maze_valid <= 1'b0;
          row        <= '0;
          col        <= '0;
        end
        FILL: begin
          maze[row] <= '1;
          if (row == ROW_LAST) begin
            row <= RW'(1);
            col <= CW'(1);
          end else begin
            row <= row + RW'(1);
          end
        end
        CARVE: begin
          maze[row][col] <= 1'b0;
          if (go_east)  maze[row][col + CW'(1)] <= 1'b0;
          if (go_north) maze[row - RW'(1)][col] <= 1'b0;
          lfsr <= lfsr_nx;
          if (col == COL_CARVE) begin
            col <= CW'(1);
            row <= row + RW'(2);
          end else begin
            col <= col + CW'(2);
          end
        end
        FINISH: begin
          maze_valid <= 1'b1;
          row        <= '0;
          col        <= '0;
`ifdef MAZE_EXIT_EN
          maze[ROWS-3][COLS-1] <= 1'b0;
          maze[ROWS-3][COLS-2] <= 1'b0;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule
